// File: rtl/pd_crc_pkg.sv
// Shared CRC32 definitions for the USB-PD PHY TX generator and RX checker.
// The CRC register is kept in MSB-first orientation; data bits enter LSB
// first, so the reported CRC is the bit-reversed, inverted register.
package pd_crc_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
   localparam int          PD_CRC_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DROP  = 2'd2,
      CHECK = 2'd3
   } pd_rx_crc_state_t;

   // One byte of reflected-input CRC32: bit 0 of the byte is shifted in first.
   function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                   input logic [7:0]  data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[31] ^ data[i]) == 1'b1) begin
            c = {c[30:0], 1'b0} ^ CRC32_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   // Bit reversal used to produce the reflected CRC output.
   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/pd_crc32_byte.sv
// Combinational CRC32 byte-step, shared between the TX generator and RX checker.
module pd_crc32_byte
   import pd_crc_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   // Advance the CRC register by one byte.
   always_comb begin
      crc_out = crc32_byte_step(crc_in, data_in);
   end

endmodule

// File: rtl/pd_rx_crc_check.sv
// USB-PD RX CRC checker: holds back the last 4 bytes of each packet, forwards
// the payload, and compares the payload CRC32 with the trailing CRC bytes.
// Optional error counter enabled by defining PD_RX_CRC_ERRCNT_EN.
module pd_rx_crc_check
   import pd_crc_pkg::*;
#(
   parameter int MAX_BYTES   = 64,
   parameter int MIN_PAYLOAD = 2
) (
   input  logic        clock,
   input  logic        rst,
`ifdef PD_RX_CRC_ERRCNT_EN
   input  logic        err_cnt_clr,
   output logic [15:0] err_cnt,
`endif
   input  logic [7:0]  din,
   input  logic        din_valid,
   input  logic        din_sop,
   input  logic        din_last,
   output logic [7:0]  dout,
   output logic        dout_valid,
   output logic        done,
   output logic        crc_ok,
   output logic        err_short,
   output logic        err_long,
   output logic        busy,
   output logic [31:0] crc_calc
);

   localparam int            CW      = $clog2(MAX_BYTES + 2);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
   localparam logic [CW-1:0] MIN_LEN = CW'(MIN_PAYLOAD + PD_CRC_BYTES);

   pd_rx_crc_state_t state_r, state_next_s;
   logic [CW-1:0]    count_r;
   logic [2:0]       fill_r;
   logic [7:0]       dl_r [0:3];
   logic [31:0]      crc_r, crc_step_s, crc_calc_s, rx_crc_s;
   logic             start_s, take_s, ovf_evt_s, check_s, crc_ok_s;

   // The oldest buffered byte is the one that enters the CRC next.
   pd_crc32_byte u_crc_step (
      .crc_in  (crc_r),
      .data_in (dl_r[0]),
      .crc_out (crc_step_s)
   );

   assign crc_calc_s = bitrev32(crc_r) ^ CRC32_XOROUT;
   assign rx_crc_s   = {dl_r[3], dl_r[2], dl_r[1], dl_r[0]};
   assign crc_ok_s   = (crc_calc_s == rx_crc_s) && (count_r >= MIN_LEN) && !err_long;

   // State register and registered busy flag.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy    <= (state_next_s != IDLE);
      end
   end

   // Decode the per-beat datapath actions from state and input qualifiers.
   always_comb begin
      start_s   = 1'b0;
      take_s    = 1'b0;
      ovf_evt_s = 1'b0;
      check_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (din_valid && din_sop) start_s = 1'b1;
            else                      start_s = 1'b0;
         end
         RECV: begin
            if (din_valid && din_sop)         start_s   = 1'b1;
            else if (din_valid && count_r == MAX_CNT) ovf_evt_s = 1'b1;
            else if (din_valid)               take_s    = 1'b1;
            else                              take_s    = 1'b0;
         end
         DROP: begin
            if (din_valid && din_sop) start_s = 1'b1;
            else                      start_s = 1'b0;
         end
         CHECK:   check_s = 1'b1;
         default: check_s = 1'b0;
      endcase
   end

   // Next-state selection; a sop always restarts, last always leads to CHECK.
   always_comb begin
      state_next_s = state_r;
      if (start_s) begin
         state_next_s = din_last ? CHECK : RECV;
      end else begin
         case (state_r)
            IDLE: state_next_s = IDLE;
            RECV: begin
               if (ovf_evt_s)             state_next_s = din_last ? CHECK : DROP;
               else if (take_s && din_last) state_next_s = CHECK;
               else                       state_next_s = RECV;
            end
            DROP: begin
               if (din_valid && din_last) state_next_s = CHECK;
               else                       state_next_s = DROP;
            end
            CHECK:   state_next_s = IDLE;
            default: state_next_s = IDLE;
         endcase
      end
   end

   // Delay line, CRC accumulation, payload output and held status flags.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         count_r    <= '0;
         fill_r     <= 3'd0;
         crc_r      <= CRC32_INIT;
         for (int i = 0; i < 4; i++) dl_r[i] <= 8'h00;
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         done       <= 1'b0;
         crc_ok     <= 1'b0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
         crc_calc   <= 32'h0000_0000;
      end else begin
         dout_valid <= 1'b0;
         done       <= 1'b0;
         if (start_s) begin
            count_r   <= CW'(1);
            fill_r    <= 3'd1;
            crc_r     <= CRC32_INIT;
            dl_r[0]   <= din;
            crc_ok    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            crc_calc  <= 32'h0000_0000;
         end else if (take_s) begin
            count_r <= count_r + CW'(1);
            if (fill_r == 3'd4) begin
               crc_r      <= crc_step_s;
               dout       <= dl_r[0];
               dout_valid <= 1'b1;
               dl_r[0]    <= dl_r[1];
               dl_r[1]    <= dl_r[2];
               dl_r[2]    <= dl_r[3];
               dl_r[3]    <= din;
            end else begin
               dl_r[fill_r[1:0]] <= din;
               fill_r            <= fill_r + 3'd1;
            end
         end else if (ovf_evt_s) begin
            count_r  <= count_r + CW'(1);
            err_long <= 1'b1;
         end else if (check_s) begin
            done      <= 1'b1;
            crc_calc  <= crc_calc_s;
            crc_ok    <= crc_ok_s;
            err_short <= (count_r < MIN_LEN);
         end else begin
            count_r <= count_r;
         end
      end
   end

`ifdef PD_RX_CRC_ERRCNT_EN
   // Saturating count of failed packets; clear has priority.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         err_cnt <= 16'h0000;
      end else if (err_cnt_clr) begin
         err_cnt <= 16'h0000;
      end else if (check_s && !crc_ok_s && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'h0001;
      end else begin
         err_cnt <= err_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_pd_rx_crc_check.sv
// Self-checking bench for pd_rx_crc_check: payload bytes and per-packet
// results are predicted by a reference CRC model and queued as stimulus is
// driven; a negedge monitor pops and compares them as the DUT produces them.
module tb_pd_rx_crc_check;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic        ok;
      logic        sh;
      logic        lg;
      logic [31:0] crc;
      int          last_cyc;
   } res_t;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic [7:0]  din   = 8'h00;
   logic        din_valid = 1'b0, din_sop = 1'b0, din_last = 1'b0;
   logic [7:0]  dout;
   logic        dout_valid, done, crc_ok, err_short, err_long, busy;
   logic [31:0] crc_calc;
`ifdef PD_RX_CRC_ERRCNT_EN
   logic        err_cnt_clr = 1'b0;
   logic [15:0] err_cnt;
`endif

   int   tests_run = 0;
   int   failed    = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   logic [7:0] exp_dout_q[$];
   res_t       exp_res_q[$];
   logic [7:0] mb;
   res_t       mr;

   pd_rx_crc_check #(.MAX_BYTES(64), .MIN_PAYLOAD(2)) dut (
      .clock      (clock),
      .rst        (rst),
`ifdef PD_RX_CRC_ERRCNT_EN
      .err_cnt_clr(err_cnt_clr),
      .err_cnt    (err_cnt),
`endif
      .din        (din),
      .din_valid  (din_valid),
      .din_sop    (din_sop),
      .din_last   (din_last),
      .dout       (dout),
      .dout_valid (dout_valid),
      .done       (done),
      .crc_ok     (crc_ok),
      .err_short  (err_short),
      .err_long   (err_long),
      .busy       (busy),
      .crc_calc   (crc_calc)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference CRC32 (standard right-shifting reflected form).
   function automatic logic [31:0] crc_ref(input bq_t d);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'h000000, d[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Scoreboard monitor.
   always @(negedge clock) begin
      if (rst === 1'b0) begin
         if (dout_valid === 1'b1) begin
            tests_run++;
            if (exp_dout_q.size() == 0) begin
               failed++;
               $display("FAIL dout_unexpected: got %h, required no output", dout);
            end else begin
               mb = exp_dout_q.pop_front();
               if (dout !== mb) begin
                  failed++;
                  $display("FAIL dout_byte: got %h, required %h", dout, mb);
               end
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            tests_run++;
            if (exp_res_q.size() == 0) begin
               failed++;
               $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
            end else begin
               mr = exp_res_q.pop_front();
               if (crc_ok !== mr.ok || err_short !== mr.sh || err_long !== mr.lg ||
                   crc_calc !== mr.crc || cyc !== mr.last_cyc + 1) begin
                  failed++;
                  $display("FAIL done_result: got ok=%b short=%b long=%b crc=%h cyc=%0d, required ok=%b short=%b long=%b crc=%h cyc=%0d",
                           crc_ok, err_short, err_long, crc_calc, cyc,
                           mr.ok, mr.sh, mr.lg, mr.crc, mr.last_cyc + 1);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drive(input logic [7:0] b, input logic s, input logic l);
      din = b; din_valid = 1'b1; din_sop = s; din_last = l;
      @(posedge clock);
      #1;
      din = 8'h00; din_valid = 1'b0; din_sop = 1'b0; din_last = 1'b0;
   endtask

   // Predict and send one complete packet; optionally probe err_long at bytes 64/65.
   task automatic send_pkt(input bq_t pkt, input int max_gap, input bit chk_long);
      int   n, nproc, npay;
      bq_t  pay;
      res_t r;
      n     = pkt.size();
      nproc = (n > 64) ? 64 : n;
      npay  = (nproc > 4) ? nproc - 4 : 0;
      for (int i = 0; i < npay; i++) begin
         pay.push_back(pkt[i]);
         exp_dout_q.push_back(pkt[i]);
      end
      r.crc = crc_ref(pay);
      r.lg  = (n > 64);
      r.sh  = !r.lg && (n < 6);
      r.ok  = !r.lg && !r.sh && (r.crc == {pkt[n-1], pkt[n-2], pkt[n-3], pkt[n-4]});
      for (int i = 0; i < n; i++) begin
         drive(pkt[i], i == 0, i == n - 1);
         if (i == n - 1) begin
            r.last_cyc = cyc;
            exp_res_q.push_back(r);
         end else if (max_gap > 0) begin
            idle($urandom_range(0, max_gap));
         end
         if (chk_long && (i == 63 || i == 64)) begin
            tests_run++;
            if (err_long !== (i == 64)) begin
               failed++;
               $display("FAIL err_long_byte%0d: got %b, required %b", i + 1, err_long, (i == 64));
            end
         end
      end
   endtask

   function automatic bq_t good_pkt(input logic [7:0] last_crc);
      bq_t p;
      p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
      p[12] = last_crc;
      return p;
   endfunction

   task automatic test_reset();
      #3;
      tests_run++;
      if ({dout, dout_valid, done, crc_ok, err_short, err_long, busy, crc_calc} !== 47'h0) begin
         failed++;
         $display("FAIL reset_outputs: got dout=%h dv=%b done=%b ok=%b sh=%b lg=%b busy=%b crc=%h, required all 0",
                  dout, dout_valid, done, crc_ok, err_short, err_long, busy, crc_calc);
      end
      idle(2);
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_good();
      send_pkt(good_pkt(8'hCB), 0, 1'b0);
      idle(4);
      tests_run++;
      if (crc_calc !== 32'hCBF43926 || crc_ok !== 1'b1 || err_short !== 1'b0 || err_long !== 1'b0) begin
         failed++;
         $display("FAIL good_held: got crc=%h ok=%b sh=%b lg=%b, required crc=cbf43926 ok=1 sh=0 lg=0",
                  crc_calc, crc_ok, err_short, err_long);
      end
      tests_run++;
      if (exp_dout_q.size() != 0 || exp_res_q.size() != 0) begin
         failed++;
         $display("FAIL good_drain: got %0d bytes %0d results pending, required 0", exp_dout_q.size(), exp_res_q.size());
      end
   endtask

   task automatic test_corrupt();
      send_pkt(good_pkt(8'hCA), 0, 1'b0);
      idle(4);
      tests_run++;
      if (crc_calc !== 32'hCBF43926 || crc_ok !== 1'b0 || err_short !== 1'b0) begin
         failed++;
         $display("FAIL corrupt_held: got crc=%h ok=%b sh=%b, required crc=cbf43926 ok=0 sh=0",
                  crc_calc, crc_ok, err_short);
      end
   endtask

   task automatic test_short();
      bq_t p;
      p = '{8'h31, 8'h32, 8'h33, 8'h34};
      send_pkt(p, 0, 1'b0);
      idle(4);
      p = '{8'h55};
      send_pkt(p, 0, 1'b0);
      idle(4);
      tests_run++;
      if (err_short !== 1'b1 || crc_ok !== 1'b0 || crc_calc !== 32'h0) begin
         failed++;
         $display("FAIL short_held: got sh=%b ok=%b crc=%h, required sh=1 ok=0 crc=0", err_short, crc_ok, crc_calc);
      end
   endtask

   task automatic test_overflow();
      bq_t p;
      for (int i = 0; i < 70; i++) p.push_back(8'(i * 7 + 3));
      send_pkt(p, 0, 1'b1);
      idle(4);
      tests_run++;
      if (err_long !== 1'b1 || crc_ok !== 1'b0 || exp_res_q.size() != 0) begin
         failed++;
         $display("FAIL overflow_held: got lg=%b ok=%b pending=%0d, required lg=1 ok=0 pending=0",
                  err_long, crc_ok, exp_res_q.size());
      end
   endtask

   task automatic test_abort();
      int d0;
      bq_t p;
      d0 = done_cnt;
      p = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      exp_dout_q.push_back(8'h41);
      for (int i = 0; i < 5; i++) drive(p[i], i == 0, 1'b0);
      send_pkt(good_pkt(8'hCB), 0, 1'b0);
      idle(4);
      tests_run++;
      if (done_cnt - d0 !== 1 || crc_ok !== 1'b1) begin
         failed++;
         $display("FAIL abort_done: got %0d dones ok=%b, required 1 done ok=1", done_cnt - d0, crc_ok);
      end
   endtask

   task automatic test_back_to_back();
      send_pkt(good_pkt(8'hCB), 0, 1'b0);
      idle(1);
      send_pkt(good_pkt(8'hCA), 0, 1'b0);
      idle(1);
      send_pkt(good_pkt(8'hCB), 0, 1'b0);
      idle(4);
      tests_run++;
      if (exp_res_q.size() != 0 || exp_dout_q.size() != 0) begin
         failed++;
         $display("FAIL b2b_drain: got %0d results %0d bytes pending, required 0", exp_res_q.size(), exp_dout_q.size());
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         bq_t p;
         logic [31:0] c;
         int len;
         len = $urandom_range(2, 20);
         for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
         c = crc_ref(p);
         if (k == 3) c = c ^ 32'h0001_0000;
         p.push_back(c[7:0]); p.push_back(c[15:8]); p.push_back(c[23:16]); p.push_back(c[31:24]);
         send_pkt(p, 3, 1'b0);
         idle(2);
      end
      idle(4);
      tests_run++;
      if (exp_res_q.size() != 0 || exp_dout_q.size() != 0) begin
         failed++;
         $display("FAIL random_drain: got %0d results %0d bytes pending, required 0", exp_res_q.size(), exp_dout_q.size());
      end
   endtask

   task automatic test_rst_mid();
      int d0;
      d0 = done_cnt;
      exp_dout_q.push_back(8'h61);
      exp_dout_q.push_back(8'h62);
      for (int i = 0; i < 7; i++) drive(8'(8'h61 + i), i == 0, 1'b0);
      tests_run++;
      if (busy !== 1'b1 || dout_valid !== 1'b1) begin
         failed++;
         $display("FAIL rst_mid_pre: got busy=%b dv=%b, required 1 1", busy, dout_valid);
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== 8'h00 || done !== 1'b0) begin
         failed++;
         $display("FAIL rst_mid_async: got busy=%b dv=%b dout=%h done=%b, required 0", busy, dout_valid, dout, done);
      end
      @(posedge clock);
      #1;
      rst = 1'b0;
      idle(4);
      tests_run++;
      if (done_cnt !== d0 || exp_dout_q.size() != 0) begin
         failed++;
         $display("FAIL rst_mid_after: got %0d dones %0d bytes pending, required 0 0", done_cnt - d0, exp_dout_q.size());
      end
   endtask

`ifdef PD_RX_CRC_ERRCNT_EN
   task automatic test_errcnt();
      err_cnt_clr = 1'b1;
      idle(1);
      err_cnt_clr = 1'b0;
      tests_run++;
      if (err_cnt !== 16'd0) begin
         failed++;
         $display("FAIL errcnt_clear: got %0d, required 0", err_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         send_pkt(good_pkt(8'hC0), 0, 1'b0);
         idle(1);
      end
      send_pkt(good_pkt(8'hCB), 0, 1'b0);
      idle(4);
      tests_run++;
      if (err_cnt !== 16'd3) begin
         failed++;
         $display("FAIL errcnt_three: got %0d, required 3", err_cnt);
      end
      send_pkt(good_pkt(8'hC0), 0, 1'b0);
      err_cnt_clr = 1'b1;
      idle(1);
      err_cnt_clr = 1'b0;
      idle(3);
      tests_run++;
      if (err_cnt !== 16'd0) begin
         failed++;
         $display("FAIL errcnt_clr_wins: got %0d, required 0", err_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_good();
      test_corrupt();
      test_short();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_random();
      test_rst_mid();
`ifdef PD_RX_CRC_ERRCNT_EN
      test_errcnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
